// File: rtl/spike_encoder_if.sv
// Frame handshake plus spike/current/count outputs of the rate encoder.
// The encoder connects through the slave modport, the frame source through master.
interface spike_encoder_if #(
    parameter int WIDTH_P = 8,
    parameter int CNT_W   = 8
);
    logic [WIDTH_P-1:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic               clear_i;
    logic               spike_o;
    logic               spike_valid_o;
    logic [WIDTH_P-1:0] current_o;
    logic [CNT_W-1:0]   spike_count_o;
    logic               done_o;

    modport master (
        output data_i, valid_i, clear_i,
        input  ready_o, spike_o, spike_valid_o, current_o, spike_count_o, done_o
    );

    modport slave (
        input  data_i, valid_i, clear_i,
        output ready_o, spike_o, spike_valid_o, current_o, spike_count_o, done_o
    );
endinterface

// File: rtl/spike_encoder.sv
// Rate encoder: one intensity per frame becomes WINDOW cycles of LFSR-compared
// spikes, followed by a one-cycle done pulse carrying the spike count.
module spike_encoder #(
    parameter int                 WIDTH_P = 8,
    parameter int                 WINDOW  = 255,
    parameter logic [WIDTH_P-1:0] SEED    = 8'hA5,
    parameter logic [WIDTH_P-1:0] WEIGHT  = 8'd128,
    parameter int                 CNT_W   = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    spike_encoder_if.slave  bus
);
    localparam int                 CW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(WINDOW - 1);
    localparam logic [WIDTH_P-1:0] TAPS     = WIDTH_P'(8'hB8);
    localparam logic [WIDTH_P-1:0] SEED_EFF =
        (SEED == '0) ? {{(WIDTH_P-1){1'b0}}, 1'b1} : SEED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH_P-1:0] level_q, level_d;
    logic [WIDTH_P-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               spike_q, spike_d;
    logic               spike_valid_q, spike_valid_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    // Single Galois step (right shift, XOR taps when the shifted-out bit is 1).
    logic [WIDTH_P-1:0] step_in;
    logic [WIDTH_P-1:0] step_out;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_P; gi++) begin : g_lfsr_step
            if (gi == WIDTH_P - 1) begin : g_msb
                assign step_out[gi] = TAPS[gi] & step_in[0];
            end else begin : g_low
                assign step_out[gi] = step_in[gi+1] ^ (TAPS[gi] & step_in[0]);
            end
        end
    endgenerate

    // The spike shown during an ENCODE cycle is computed on the edge before it,
    // so lfsr_q always holds the value for the next spike to be produced.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        lfsr_d        = lfsr_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        count_d       = count_q;
        spike_d       = spike_q;
        spike_valid_d = spike_valid_q;
        done_d        = 1'b0;
        ready_d       = ready_q;
        step_in       = lfsr_q;

        if (bus.clear_i) begin
            state_d       = ST_IDLE;
            spike_d       = 1'b0;
            spike_valid_d = 1'b0;
            ready_d       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        step_in       = SEED_EFF;
                        level_d       = bus.data_i;
                        lfsr_d        = step_out;
                        cnt_d         = '0;
                        spike_d       = (SEED_EFF < bus.data_i);
                        acc_d         = {{(CNT_W-1){1'b0}}, spike_d};
                        spike_valid_d = 1'b1;
                        ready_d       = 1'b0;
                        state_d       = ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (cnt_q == LAST_CNT) begin
                        spike_d       = 1'b0;
                        spike_valid_d = 1'b0;
                        done_d        = 1'b1;
                        count_d       = acc_q;
                        state_d       = ST_DONE;
                    end else begin
                        spike_d       = (lfsr_q < level_q);
                        acc_d         = acc_q + {{(CNT_W-1){1'b0}}, spike_d};
                        lfsr_d        = step_out;
                        cnt_d         = cnt_q + 1'b1;
                        spike_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    spike_d       = 1'b0;
                    spike_valid_d = 1'b0;
                    ready_d       = 1'b1;
                    state_d       = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            level_q       <= '0;
            lfsr_q        <= SEED_EFF;
            cnt_q         <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.ready_o       = ready_q;
    assign bus.spike_o       = spike_q;
    assign bus.spike_valid_o = spike_valid_q;
    assign bus.done_o        = done_q;
    assign bus.spike_count_o = count_q;
    assign bus.current_o     = spike_q ? WEIGHT : '0;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: frame scoreboard against a software Galois
// model, boundary intensities, back-to-back reseed, clear and async reset.
module tb_spike_encoder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    spike_encoder_if #(.WIDTH_P(8), .CNT_W(8)) bus ();

    spike_encoder #(
        .WIDTH_P(8),
        .WINDOW (255),
        .SEED   (8'hA5),
        .WEIGHT (8'd128),
        .CNT_W  (8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gstep(input logic [7:0] v);
        logic [7:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 8'hB8;
        return s;
    endfunction

    // Runs one full frame; the bench is at posedge+1 of an IDLE cycle on entry and exit.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] exp_cnt,
                             input bit hold, input string nm, output logic [254:0] seq);
        logic [7:0] m;
        logic       exp_sp;
        logic [7:0] exp_cur;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        tests++;
        if (bus.ready_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready_idle: got %b want 1", nm, bus.ready_o);
        end
        @(posedge clk); #1;
        if (!hold) bus.valid_i = 1'b0;
        m = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            exp_sp  = (m < d);
            exp_cur = exp_sp ? 8'd128 : 8'd0;
            tests++;
            if (bus.spike_valid_o !== 1'b1 || bus.spike_o !== exp_sp ||
                bus.current_o !== exp_cur || bus.done_o !== 1'b0 || bus.ready_o !== 1'b0) begin
                fails++;
                $display("FAIL %s_cycle%0d: got v=%b s=%b cur=%0d done=%b rdy=%b want v=1 s=%b cur=%0d done=0 rdy=0",
                         nm, i, bus.spike_valid_o, bus.spike_o, bus.current_o, bus.done_o,
                         bus.ready_o, exp_sp, exp_cur);
            end
            seq[i] = bus.spike_o;
            m = gstep(m);
            @(posedge clk); #1;
        end
        tests++;
        if (bus.done_o !== 1'b1 || bus.spike_valid_o !== 1'b0 || bus.spike_o !== 1'b0 ||
            bus.current_o !== 8'd0 || bus.spike_count_o !== exp_cnt || bus.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: got done=%b v=%b s=%b cur=%0d cnt=%0d rdy=%b want done=1 v=0 s=0 cur=0 cnt=%0d rdy=0",
                     nm, bus.done_o, bus.spike_valid_o, bus.spike_o, bus.current_o,
                     bus.spike_count_o, bus.ready_o, exp_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.spike_valid_o !== 1'b0 ||
            bus.spike_count_o !== exp_cnt) begin
            fails++;
            $display("FAIL %s_after: got done=%b rdy=%b v=%b cnt=%0d want done=0 rdy=1 v=0 cnt=%0d",
                     nm, bus.done_o, bus.ready_o, bus.spike_valid_o, bus.spike_count_o, exp_cnt);
        end
        $display("[TB] frame %s data=%0d count=%0d expected=%0d", nm, d, bus.spike_count_o, exp_cnt);
    endtask

    task automatic check_reset_vals(input string nm);
        tests++;
        if (bus.ready_o !== 1'b1 || bus.spike_o !== 1'b0 || bus.spike_valid_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.current_o !== 8'd0 || bus.spike_count_o !== 8'd0) begin
            fails++;
            $display("FAIL %s: got rdy=%b s=%b v=%b done=%b cur=%0d cnt=%0d want rdy=1 s=0 v=0 done=0 cur=0 cnt=0",
                     nm, bus.ready_o, bus.spike_o, bus.spike_valid_o, bus.done_o,
                     bus.current_o, bus.spike_count_o);
        end
        $display("[TB] %s checked", nm);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.data_i  = 8'd0;
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        #12;
        check_reset_vals("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("reset_release");
    endtask

    task automatic test_frame_100();
        logic [254:0] s;
        run_frame(8'd100, 8'd99, 1'b0, "level100", s);
    endtask

    task automatic test_boundaries();
        logic [254:0] s;
        run_frame(8'd0, 8'd0, 1'b0, "level0", s);
        tests++;
        if (s !== '0) begin
            fails++;
            $display("FAIL level0_no_spikes: got %h want 0", s);
        end
        run_frame(8'd255, 8'd254, 1'b0, "level255", s);
    endtask

    task automatic test_back_to_back();
        logic [254:0] s1;
        logic [254:0] s2;
        run_frame(8'd37, 8'd36, 1'b1, "b2b_first", s1);
        run_frame(8'd37, 8'd36, 1'b1, "b2b_second", s2);
        bus.valid_i = 1'b0;
        tests++;
        if (s1 !== s2) begin
            fails++;
            $display("FAIL b2b_identical: got %h want %h", s2, s1);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.spike_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
                fails++;
                $display("FAIL b2b_no_third%0d: got v=%b rdy=%b want v=0 rdy=1",
                         i, bus.spike_valid_o, bus.ready_o);
            end
        end
        $display("[TB] back_to_back done");
    endtask

    task automatic test_clear();
        logic [254:0] s;
        bus.data_i  = 8'd200;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (bus.spike_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL clear_pre_active: got v=%b want 1", bus.spike_valid_o);
        end
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        tests++;
        if (bus.spike_valid_o !== 1'b0 || bus.spike_o !== 1'b0 || bus.done_o !== 1'b0 ||
            bus.ready_o !== 1'b1 || bus.spike_count_o !== 8'd36) begin
            fails++;
            $display("FAIL clear_abort: got v=%b s=%b done=%b rdy=%b cnt=%0d want v=0 s=0 done=0 rdy=1 cnt=36",
                     bus.spike_valid_o, bus.spike_o, bus.done_o, bus.ready_o, bus.spike_count_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.done_o !== 1'b0 || bus.spike_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL clear_quiet%0d: got done=%b v=%b want 0 0", i, bus.done_o, bus.spike_valid_o);
            end
        end
        bus.data_i  = 8'd90;
        bus.valid_i = 1'b1;
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        tests++;
        if (bus.spike_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            fails++;
            $display("FAIL clear_blocks_accept: got v=%b rdy=%b want v=0 rdy=1", bus.spike_valid_o, bus.ready_o);
        end
        $display("[TB] clear abort checked");
        run_frame(8'd55, 8'd54, 1'b0, "after_clear", s);
    endtask

    task automatic test_reset_mid();
        logic [254:0] s;
        bus.data_i  = 8'd100;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_frame");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.done_o !== 1'b0 || bus.spike_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_quiet%0d: got done=%b v=%b want 0 0", i, bus.done_o, bus.spike_valid_o);
            end
        end
        run_frame(8'd10, 8'd9, 1'b0, "after_reset", s);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_frame_100();
        test_boundaries();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
